cfm_write_engine: RTL
=====================

Name: cfm_write_engine

Overview:
- Responder for the command state machine's flash-write requests.
- `start_addr` loads a start address; each `start_wrdata` carries one 32-bit word.
- The block writes each word to the MAX10 on-chip flash Avalon-MM data port, polls the CSR status register until the write completes, then pulses `done_data`.
- Sits between the command state machine and the on-chip flash IP; the CSR write-protect setup is done by a separate block.

Parameters:
- ADDR_W, 22, width of the flash data-port word address.
- TIMEOUT_CYC, 65535, maximum status-poll cycles per word before `err` is flagged.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start_addr  in  1  one-cycle pulse: load `addr_word` as the start address
- addr_word  in  32  byte address; word address = `addr_word[ADDR_W+1:2]`
- start_wrdata  in  1  one-cycle pulse: write `wr_word` at the current address
- wr_word  in  32  data word to program
- done_data  out  1  one-cycle pulse: word finished (success or error)
- err  out  1  sticky error flag; cleared by `start_addr` or reset
- busy  out  1  high from accepted `start_wrdata` until `done_data`
- avmm_data_addr  out  ADDR_W  flash data-port word address
- avmm_data_write  out  1  data-port write strobe
- avmm_data_read  out  1  data-port read strobe (optional feature only)
- avmm_data_writedata  out  32  data-port write data
- avmm_data_readdata  in  32  data-port read data
- avmm_data_readdatavalid  in  1  data-port read data valid
- avmm_data_waitrequest  in  1  data-port stall
- avmm_csr_addr  out  1  CSR address; always 0 (status register)
- avmm_csr_read  out  1  CSR read strobe
- avmm_csr_readdata  in  32  status: [1:0] busy code (00 idle), [3] write-successful

Behaviour:
- Reset: all outputs 0, internal address 0, FSM in IDLE.

States:
- IDLE
  - `start_addr`: latch word address, clear `err`.
  - `start_wrdata`: latch `wr_word`, set `busy`, go to WR.
  - Both pulses in the same cycle: the address is loaded first, and the write targets the new address.
- WR
  - Hold `avmm_data_write`, address and data stable until a cycle with `waitrequest` = 0.
  - That cycle completes the write; go to POLL.
- POLL
  - Assert `avmm_csr_read` for one cycle; the CSR returns data on the next cycle (fixed latency 1). Go to CHK.
- CHK
  - busy code != 00: increment the poll counter and return to POLL.
  - If the counter reaches TIMEOUT_CYC: set `err` and go to DONE.
  - busy code == 00: bit3 = 0 sets `err`; then go to DONE (or VERIFY when compiled in).
- DONE
  - Pulse `done_data` for one cycle, clear `busy`.
  - Increment the word address modulo 2^ADDR_W (wraps to 0).
  - Go to IDLE.

Latency and handshakes:
- With `waitrequest` low and the first poll returning idle+ws, `done_data` rises 4 cycles after `start_wrdata`.
- `start_addr` and `start_wrdata` arriving while `busy` is high are ignored, with no queuing.
- The address advances even when a word sets `err`.
- Reset mid-operation deasserts all strobes in the same cycle, returns to IDLE, and produces no `done_data`.

Optional Feature:
- Macro: CFM_WRITE_VERIFY_EN
- Defined:
  - After successful status, go to VERIFY.
  - Assert `avmm_data_read` at the same address until `waitrequest` = 0.
  - Wait for `readdatavalid`; a mismatch with the latched word sets `err`.
  - Then go to DONE. This adds at least 2 cycles of latency.
- Undefined: VERIFY does not exist, `avmm_data_read` is tied to 0, and the read inputs are unused.

Test Plan:
- Address load and single write:
  - Stimulus: `start_addr` with `addr_word` = 0x00AC0010, then `start_wrdata` with `wr_word` = 0x12345678; `waitrequest` = 0; status returns 0x08.
  - Required: one write to address 0x2B0004 with data 0x12345678; `done_data` 4 cycles after `start_wrdata`; `err` = 0.
- Four back-to-back words with `waitrequest` high for 3 cycles each:
  - Required: `write` is held 4 cycles per word with stable address and data.
  - Required: addresses are 0x2B0004..0x2B0007; exactly four `done_data` pulses.
- Status busy code 10 for 5 polls, then 0x08:
  - Required: 6 CSR reads; `done_data` after the last read; `err` = 0.
- Error and timeout:
  - Status returns 0x00 (idle, ws = 0) → `err` = 1 and `done_data` pulses.
  - TIMEOUT_CYC = 8 with status held at 0x02 → `err` = 1 after 8 polls; the address still increments.
- Wrap and ignored pulses:
  - Address 0x3FFFFF, write, then write again → second write targets 0x000000.
  - `start_wrdata` while `busy` → ignored, no extra write.
- Reset mid-operation and verify:
  - Reset during POLL → strobes low the same cycle, `busy` = 0, no `done_data`.
  - With CFM_WRITE_VERIFY_EN and readback 0x12345679 → `err` = 1.

Source files
------------

// File: rtl/cfm_write_engine.sv
// cfm_write_engine: programs 32-bit words into the MAX10 on-chip flash data port
// and polls the CSR status until each write retires. Optional readback: CFM_WRITE_VERIFY_EN.
module cfm_write_engine #(
   parameter int ADDR_W      = 22,
   parameter int TIMEOUT_CYC = 65535
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start_addr,
   input  logic [31:0]       addr_word,
   input  logic              start_wrdata,
   input  logic [31:0]       wr_word,
   output logic              done_data,
   output logic              err,
   output logic              busy,
   output logic [ADDR_W-1:0] avmm_data_addr,
   output logic              avmm_data_write,
   output logic              avmm_data_read,
   output logic [31:0]       avmm_data_writedata,
   input  logic [31:0]       avmm_data_readdata,
   input  logic              avmm_data_readdatavalid,
   input  logic              avmm_data_waitrequest,
   output logic              avmm_csr_addr,
   output logic              avmm_csr_read,
   input  logic [31:0]       avmm_csr_readdata
);

   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] LP_TMO = CNT_W'(TIMEOUT_CYC);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR,
      S_POLL,
      S_CHK,
      S_DONE
`ifdef CFM_WRITE_VERIFY_EN
      ,
      S_VERIFY,
      S_VWAIT
`endif
   } state_t;

   state_t r_state;
   state_t w_next;

   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_data;
   logic              r_err;
   logic [CNT_W-1:0]  r_cnt;

   logic             w_stat_busy;
   logic             w_stat_ws;
   logic [CNT_W-1:0] w_cnt_inc;
   logic             w_tmo;
   logic             w_idle;
   logic             w_unused;

   assign w_stat_busy = |avmm_csr_readdata[1:0];
   assign w_stat_ws   = avmm_csr_readdata[3];
   assign w_cnt_inc   = r_cnt + 1'b1;
   assign w_tmo       = (w_cnt_inc == LP_TMO);
   assign w_idle      = (r_state == S_IDLE);

   // Byte-address bits outside the word window and reserved status bits are ignored.
   assign w_unused = ^{addr_word[31:ADDR_W+2], addr_word[1:0],
                       avmm_csr_readdata[31:4], avmm_csr_readdata[2],
                       avmm_data_readdata, avmm_data_readdatavalid};

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (start_wrdata) begin
               w_next = S_WR;
            end
         end
         S_WR: begin
            if (!avmm_data_waitrequest) begin
               w_next = S_POLL;
            end
         end
         S_POLL: begin
            w_next = S_CHK;
         end
         S_CHK: begin
            if (w_stat_busy) begin
               w_next = w_tmo ? S_DONE : S_POLL;
            end else begin
`ifdef CFM_WRITE_VERIFY_EN
               w_next = w_stat_ws ? S_VERIFY : S_DONE;
`else
               w_next = S_DONE;
`endif
            end
         end
`ifdef CFM_WRITE_VERIFY_EN
         S_VERIFY: begin
            if (!avmm_data_waitrequest) begin
               w_next = S_VWAIT;
            end
         end
         S_VWAIT: begin
            if (avmm_data_readdatavalid) begin
               w_next = S_DONE;
            end
         end
`endif
         S_DONE: begin
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // A same-cycle address load lands before the write, so the write uses it.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_addr <= '0;
         r_data <= '0;
         r_err  <= 1'b0;
         r_cnt  <= '0;
      end else begin
         if (w_idle && start_addr) begin
            r_addr <= addr_word[ADDR_W+1:2];
            r_err  <= 1'b0;
         end
         if (w_idle && start_wrdata) begin
            r_data <= wr_word;
            r_cnt  <= '0;
         end
         if (r_state == S_CHK) begin
            if (w_stat_busy) begin
               r_cnt <= w_cnt_inc;
               if (w_tmo) begin
                  r_err <= 1'b1;
               end
            end else if (!w_stat_ws) begin
               r_err <= 1'b1;
            end
         end
`ifdef CFM_WRITE_VERIFY_EN
         if ((r_state == S_VWAIT) && avmm_data_readdatavalid &&
             (avmm_data_readdata != r_data)) begin
            r_err <= 1'b1;
         end
`endif
         if (r_state == S_DONE) begin
            r_addr <= r_addr + 1'b1;
         end
      end
   end

   // Strobes are gated by reset so a mid-operation reset drops them at once.
   always_comb begin
      avmm_data_write = 1'b0;
      avmm_data_read  = 1'b0;
      avmm_csr_read   = 1'b0;
      done_data       = 1'b0;
      busy            = 1'b0;
      if (!reset) begin
         avmm_data_write = (r_state == S_WR);
         avmm_csr_read   = (r_state == S_POLL);
         done_data       = (r_state == S_DONE);
         busy            = !w_idle;
`ifdef CFM_WRITE_VERIFY_EN
         avmm_data_read  = (r_state == S_VERIFY);
`endif
      end
   end

   assign err                 = r_err & !reset;
   assign avmm_data_addr      = r_addr;
   assign avmm_data_writedata = r_data;
   assign avmm_csr_addr       = 1'b0;

endmodule
